inv_converter16: RTL and testbench



---
 rtl/inv_converter16.sv | 82 ++++++++
 tb/tb_inv_converter16.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/inv_converter16.sv
// Purpose: registered 16-bit two's-complement negator (-data_i) with valid strobe and overflow flag.
// Latency: exactly one clk cycle from data_i/valid_i to inv_o/valid_o/ovf_o.
// Backpressure: none; a new operand is accepted every cycle and valid_i only qualifies the output.
module inv_converter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [15:0] data_i,
    output logic [15:0] inv_o,
    output logic        valid_o,
    output logic        ovf_o
);

    // Bitwise-inverted operand feeding the incrementer.
    logic [15:0] w_inv;

    // Group propagate for the lower three 4-bit groups; the top group's
    // propagate would only feed the discarded carry-out, so it is not built.
    logic [2:0]  w_grp_p;

    // Carry into each 4-bit group (group 0 receives the +1).
    logic [3:0]  w_grp_cin;

    // Carry into each individual bit.
    logic [15:0] w_bit_cin;

    // Negated result and overflow detect, before registering.
    logic [15:0] w_sum;
    logic        w_ovf;

    // Output flops.
    logic [15:0] r_inv;
    logic        r_vld;
    logic        r_ovf;

    assign w_inv = ~data_i;

    // A group propagates the increment carry only if all its inverted bits are 1.
    for (genvar g = 0; g < 3; g++) begin : g_grp_p
        assign w_grp_p[g] = &w_inv[4*g +: 4];
    end

    // Lookahead across groups: the +1 enters group 0 and reaches group g
    // only if every lower group propagates.
    assign w_grp_cin[0] = 1'b1;
    assign w_grp_cin[1] = w_grp_p[0];
    assign w_grp_cin[2] = &w_grp_p[1:0];
    assign w_grp_cin[3] = &w_grp_p[2:0];

    // Lookahead within each group: a bit sees the carry when the group
    // carry-in is set and every lower inverted bit of the group is 1.
    for (genvar g = 0; g < 4; g++) begin : g_bit_cin
        assign w_bit_cin[4*g]     = w_grp_cin[g];
        assign w_bit_cin[4*g + 1] = w_grp_cin[g] & w_inv[4*g];
        assign w_bit_cin[4*g + 2] = w_grp_cin[g] & (&w_inv[4*g +: 2]);
        assign w_bit_cin[4*g + 3] = w_grp_cin[g] & (&w_inv[4*g +: 3]);
    end

    // Increment sum; the carry out of bit 15 is dropped (modulo 2^16).
    assign w_sum = w_inv ^ w_bit_cin;

    // Only the most negative value has no representable negation.
    assign w_ovf = (data_i == 16'h8000);

    // Capture the result every cycle; reset clears all outputs asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv <= 16'h0000;
            r_vld <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_inv <= w_sum;
            r_vld <= valid_i;
            r_ovf <= w_ovf;
        end
    end

    assign inv_o   = r_inv;
    assign valid_o = r_vld;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_inv_converter16.sv
// Purpose: scoreboard bench for inv_converter16 with randomized and directed operands.
// Latency: expects every operand driven before an edge to appear one edge later.
// Backpressure: none; the driver pushes one expected entry per driven cycle.
module tb_inv_converter16;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [15:0] data_i;
    logic [15:0] inv_o;
    logic        valid_o;
    logic        ovf_o;

    typedef struct packed {
        logic [15:0] inv;
        logic        ovf;
        logic        vld;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    inv_converter16 dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data_i  (data_i),
        .inv_o   (inv_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    // 20 ns clock period.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: negation as plain modular arithmetic.
    function automatic exp_t model(input logic [15:0] d, input logic v);
        exp_t e;
        int   neg;
        neg   = (65536 - int'(d)) % 65536;
        e.inv = neg[15:0];
        e.ovf = (int'(d) == 32768);
        e.vld = v;
        return e;
    endfunction

    // Drive one operand between edges and record what should come out after the next edge.
    task automatic drive(input logic [15:0] d, input logic v);
        @(negedge clk);
        data_i  = d;
        valid_i = v;
        exp_q.push_back(model(d, v));
    endtask

    // Monitor: after each edge out of reset, pop one expected entry and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("inv_o",   inv_o,          e.inv);
                check("ovf_o",   {15'd0, ovf_o},  {15'd0, e.ovf});
                check("valid_o", {15'd0, valid_o},{15'd0, e.vld});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        if (!done) begin
            $display("FAIL watchdog: bench did not finish, time %0t", $time);
            $fatal(1, "timeout");
        end
    end

    initial begin
        logic [15:0] specials [6];
        logic [15:0] d;
        logic [15:0] one;
        specials[0] = 16'h0000; specials[1] = 16'h8000; specials[2] = 16'h7FFF;
        specials[3] = 16'hFFFF; specials[4] = 16'h0001; specials[5] = 16'h8001;

        // Reset held with live data: outputs must stay cleared.
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            check("rst_inv", inv_o, 16'h0000);
            check("rst_vld", {15'd0, valid_o}, 16'h0000);
            check("rst_ovf", {15'd0, ovf_o}, 16'h0000);
        end
        rst = 1'b0;
        exp_q.push_back(model(16'h1234, 1'b1));   // first edge after release captures 0x1234

        // Basic values.
        drive(16'h0001, 1'b1);
        drive(16'h0000, 1'b1);
        drive(16'hFFFF, 1'b1);
        drive(16'h7FFF, 1'b1);

        // Overflow and its neighbour.
        drive(16'h8000, 1'b1);
        drive(16'h8001, 1'b1);

        // Carry-chain walk across every lookahead group boundary.
        for (int k = 0; k < 16; k++) begin
            one = 16'h0001;
            drive(one << k, k[0]);
        end

        // Random sweep with toggling qualifier and occasional special values.
        for (int i = 0; i < 51; i++) begin
            if ($urandom_range(0, 5) == 0)
                d = specials[$urandom_range(0, 5)];
            else
                d = 16'($urandom);
            drive(d, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-stream: result 0xEDCC is visible, then cleared between edges.
        drive(16'h1234, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_inv", inv_o, 16'hEDCC);
        #1;
        rst = 1'b1;
        #1;
        check("async_inv", inv_o, 16'h0000);
        check("async_vld", {15'd0, valid_o}, 16'h0000);
        @(negedge clk);
        check("held_inv", inv_o, 16'h0000);
        rst = 1'b0;
        exp_q.push_back(model(data_i, valid_i));  // next edge captures current inputs
        drive(16'h8000, 1'b0);
        drive(16'h0010, 1'b1);

        // Drain and confirm every expected entry was consumed.
        repeat (2) @(negedge clk);
        check("queue_left", 16'(exp_q.size()), 16'h0000);

        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
